// File: rtl/npu_result_writer_pkg.sv
// Shared types and field positions for the NPU result writer: FSM states,
// host command word layout and status word layout.
package npu_result_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // control_reg layout
  localparam int START_BIT = 31;
  localparam int MODE_BIT  = 30;
  localparam int BASE_LSB  = 15;
  localparam int CNT_LSB   = 0;

  // ready layout
  localparam int DONE_BIT  = 0;
  localparam int BUSY_BIT  = 1;
  localparam int DROP_LSB  = 16;
  localparam int DROP_W    = 16;

endpackage

// File: rtl/npu_result_writer_if.sv
// Host command, NPU result stream and RAM write port of the result writer.
// The writer connects through the slave modport; its environment uses master.
interface npu_result_writer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic [31:0]       control_reg;
  logic [DATA_W-1:0] d_in;
  logic              d_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic              busy;
  logic [31:0]       ready;
  logic [31:0]       answer;

  modport master (
    output control_reg, d_in, d_valid,
    input  ram_addr, ram_data, ram_we, busy, ready, answer
  );

  modport slave (
    input  control_reg, d_in, d_valid,
    output ram_addr, ram_data, ram_we, busy, ready, answer
  );
endinterface

// File: rtl/npu_result_writer_argmax_tracker.sv
// Running unsigned maximum and its index; strict-greater update so ties keep
// the earliest index.
module npu_argmax_tracker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] value,
  input  logic [CNT_W-1:0]  index,
  output logic [DATA_W-1:0] max_val,
  output logic [CNT_W-1:0]  max_idx
);

  logic [DATA_W-1:0] max_val_q;
  logic [CNT_W-1:0]  max_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (clr) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (en && (value > max_val_q)) begin
      max_val_q <= value;
      max_idx_q <= index;
    end
  end

  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

endmodule

// File: rtl/npu_result_writer.sv
// Drains the NPU result byte stream into a RAM write port, tracking argmax in
// dense mode. Define NPU_RESULT_DROP_CNT_EN to count strobes seen outside capture.
module npu_result_writer
  import npu_result_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  npu_result_writer_if.slave   bus
);

  state_e            state_q, state_d;
  logic              start_prev_q;
  logic              mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;

  logic              start_req;
  logic              start_acc;
  logic              capture_en;
  logic              last_byte;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] max_val;
  logic [CNT_W-1:0]  max_idx;
  logic [31:0]       answer_w;
  logic [DROP_W-1:0] drop_cnt;

  assign cmd_count  = bus.control_reg[CNT_LSB +: CNT_W];
  assign start_req  = bus.control_reg[START_BIT] & ~start_prev_q;
  // A rising start during an active capture is deliberately dropped.
  assign start_acc  = start_req && (state_q != CAPTURE);
  assign capture_en = (state_q == CAPTURE) && bus.d_valid;
  assign last_byte  = capture_en && (wr_cnt_q == (count_q - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = (cmd_count == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (last_byte) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_prev_q <= 1'b0;
      mode_q       <= 1'b0;
      base_q       <= '0;
      count_q      <= '0;
      wr_cnt_q     <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
    end else begin
      start_prev_q <= bus.control_reg[START_BIT];
      ram_we_q     <= capture_en;
      if (start_acc) begin
        mode_q   <= bus.control_reg[MODE_BIT];
        base_q   <= bus.control_reg[BASE_LSB +: ADDR_W];
        count_q  <= cmd_count;
        wr_cnt_q <= '0;
      end else if (capture_en) begin
        // Address wraps silently modulo 2^ADDR_W.
        ram_addr_q <= base_q + ADDR_W'(wr_cnt_q);
        ram_data_q <= bus.d_in;
        wr_cnt_q   <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

  npu_argmax_tracker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (start_acc),
    .en      (capture_en && mode_q),
    .value   (bus.d_in),
    .index   (wr_cnt_q),
    .max_val (max_val),
    .max_idx (max_idx)
  );

  always_comb begin
    answer_w = '0;
    if ((state_q == DONE) && mode_q) begin
      answer_w[16 +: DATA_W] = max_val;
      answer_w[0 +: CNT_W]   = max_idx;
    end
  end

`ifdef NPU_RESULT_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (start_acc) begin
      drop_q <= '0;
    end else if (bus.d_valid && (state_q != CAPTURE) && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.busy     = (state_q == CAPTURE);
  assign bus.answer   = answer_w;
  assign bus.ready    = {drop_cnt, 14'b0, (state_q == CAPTURE), (state_q == DONE)};

endmodule

// File: tb/tb_npu_result_writer.sv
// Self-checking bench for npu_result_writer: table-driven vectors, directed
// multi-cycle corner cases and randomized transactions against a reference model.
module tb_npu_result_writer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npu_result_writer_if #(.ADDR_W(15), .DATA_W(8)) bus ();

  npu_result_writer #(.ADDR_W(15), .DATA_W(8), .CNT_W(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [14:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  txn_bytes [16];

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.ram_we === 1'b1) begin
      wa.push_back(bus.ram_addr);
      wd.push_back(bus.ram_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference argmax: first index holding the largest unsigned byte.
  function automatic logic [31:0] model_answer(input logic m, input int cnt);
    int best = 0;
    int bi = 0;
    if (!m) return 32'h0;
    for (int i = 0; i < cnt; i++) begin
      if (int'(txn_bytes[i]) > best) begin
        best = int'(txn_bytes[i]);
        bi = i;
      end
    end
    return (32'(best) << 16) | 32'(bi);
  endfunction

  logic done_last, we_last, busy_last, early_done;

  // Called at a negedge; returns two negedges after the final write.
  task automatic run_txn(input logic m, input logic [14:0] b, input int cnt, input int gap_max);
    wa.delete();
    wd.delete();
    early_done = 1'b0;
    bus.control_reg = {1'b1, m, b, 15'(cnt)};
    @(negedge clk);
    bus.control_reg[31] = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (i > 0 && bus.ready[0] === 1'b1) early_done = 1'b1;
      if (g > 0) begin
        bus.d_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      bus.d_in = txn_bytes[i];
      bus.d_valid = 1'b1;
      @(negedge clk);
    end
    done_last = bus.ready[0];
    we_last   = bus.ram_we;
    busy_last = bus.busy;
    bus.d_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_txn(input string name, input logic m, input logic [14:0] b,
                           input int cnt, input logic [31:0] exp_answer);
    check({name, " write count"}, 32'(wa.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < wa.size(); i++) begin
      logic [14:0] ea = b + 15'(i);
      check({name, " addr"}, 32'(wa[i]), 32'(ea));
      check({name, " data"}, 32'(wd[i]), 32'(txn_bytes[i]));
    end
    check({name, " done with last write"}, 32'({done_last, we_last, busy_last}), 32'b110);
    check({name, " no early done"}, 32'(early_done), 32'd0);
    check({name, " ready held"}, bus.ready & 32'h3, 32'h1);
    check({name, " answer"}, bus.answer, exp_answer);
    $display("txn %s mode=%0d base=0x%04h count=%0d writes=%0d answer=0x%08h",
             name, m, b, cnt, wa.size(), bus.answer);
  endtask

  typedef struct {
    logic        mode;
    logic [14:0] base;
    int          count;
    logic [31:0] exp_answer;
    logic [14:0] exp_last;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] vec_bytes [5][10];

  initial begin
    logic busy_ok;

    vecs[0] = '{1'b0, 15'h0100, 4,  32'h0000_0000, 15'h0103};
    vecs[1] = '{1'b1, 15'h0000, 10, 32'h0009_0001, 15'h0009};
    vecs[2] = '{1'b0, 15'h7FFE, 3,  32'h0000_0000, 15'h0000};
    vecs[3] = '{1'b1, 15'h7FFF, 3,  32'h0000_0000, 15'h0001};
    vecs[4] = '{1'b1, 15'h0020, 3,  32'h00FF_0002, 15'h0022};
    vec_bytes[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec_bytes[1] = '{8'd3, 8'd9, 8'd7, 8'd9, 8'd1, 8'd0, 8'd2, 8'd9, 8'd5, 8'd4};
    vec_bytes[2] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec_bytes[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec_bytes[4] = '{8'h01, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    reset = 1'b0;
    bus.control_reg = 32'h0;
    bus.d_in = 8'h00;
    bus.d_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ram_we", 32'(bus.ram_we), 32'h0);
    check("reset ram_addr", 32'(bus.ram_addr), 32'h0);
    check("reset ram_data", 32'(bus.ram_data), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset ready", bus.ready, 32'h0);
    check("reset answer", bus.answer, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Strobes while idle: never written, only counted by the optional counter.
    wa.delete();
    wd.delete();
    repeat (3) begin
      bus.d_in = 8'h5A;
      bus.d_valid = 1'b1;
      @(negedge clk);
    end
    bus.d_valid = 1'b0;
    @(negedge clk);
    check("idle strobes no write", 32'(wa.size()), 32'd0);
`ifdef NPU_RESULT_DROP_CNT_EN
    check("drop count after 3", 32'(bus.ready[31:16]), 32'd3);
`else
    check("drop field tied low", 32'(bus.ready[31:16]), 32'd0);
`endif
    bus.control_reg = {1'b1, 1'b0, 15'h0000, 15'd0};
    @(negedge clk);
    bus.control_reg[31] = 1'b0;
    check("count0 done next cycle", bus.ready, 32'h1);
    @(negedge clk);
    check("count0 no write", 32'(wa.size()), 32'd0);

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 10; j++) txn_bytes[j] = vec_bytes[v][j];
      run_txn(vecs[v].mode, vecs[v].base, vecs[v].count, 0);
      check_txn($sformatf("vec%0d", v), vecs[v].mode, vecs[v].base, vecs[v].count, vecs[v].exp_answer);
      if (wa.size() == vecs[v].count)
        check($sformatf("vec%0d last addr", v), 32'(wa[vecs[v].count-1]), 32'(vecs[v].exp_last));
    end

    // Gapped strobes with a start pulse mid-capture that must be ignored.
    wa.delete();
    wd.delete();
    busy_ok = 1'b1;
    bus.control_reg = {1'b1, 1'b0, 15'h0010, 15'd2};
    @(negedge clk);
    bus.control_reg[31] = 1'b0;
    bus.d_in = 8'hA1;
    bus.d_valid = 1'b1;
    @(negedge clk);
    bus.d_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (k == 1) bus.control_reg = {1'b1, 1'b0, 15'h0050, 15'd2};
      if (k == 2) bus.control_reg[31] = 1'b0;
      @(negedge clk);
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    check("gap busy throughout", 32'(busy_ok), 32'd1);
    check("gap one write so far", 32'(wa.size()), 32'd1);
    bus.d_in = 8'hA2;
    bus.d_valid = 1'b1;
    @(negedge clk);
    bus.d_valid = 1'b0;
    check("gap done on last write", 32'({bus.ready[0], bus.ram_we}), 32'b11);
    repeat (3) @(negedge clk);
    check("gap write count", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("gap addr0", 32'(wa[0]), 32'h0010);
      check("gap addr1", 32'(wa[1]), 32'h0011);
      check("gap data1", 32'(wd[1]), 32'h00A2);
    end
    $display("txn gapped-restart writes=%0d ready=0x%08h", wa.size(), bus.ready);

    // Start and strobe together while DONE: the start wins, the byte is dropped.
    wa.delete();
    wd.delete();
    bus.control_reg = {1'b1, 1'b0, 15'h0400, 15'd2};
    bus.d_in = 8'hEE;
    bus.d_valid = 1'b1;
    @(negedge clk);
    bus.control_reg[31] = 1'b0;
    bus.d_valid = 1'b0;
    check("start-wins busy", 32'(bus.busy), 32'd1);
    check("start-wins no write", 32'(bus.ram_we), 32'd0);
    for (int i = 0; i < 2; i++) begin
      bus.d_in = 8'(i + 1);
      bus.d_valid = 1'b1;
      @(negedge clk);
    end
    bus.d_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("start-wins write count", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("start-wins addr0", 32'(wa[0]), 32'h0400);
      check("start-wins data0", 32'(wd[0]), 32'h0001);
    end
    $display("txn start-wins writes=%0d ready=0x%08h", wa.size(), bus.ready);

    for (int t = 0; t < 20; t++) begin
      logic        m = 1'($urandom_range(0, 1));
      int          cnt = int'($urandom_range(1, 12));
      int          lim = ($urandom_range(0, 1) == 0) ? 3 : 255;
      logic [14:0] b = ($urandom_range(0, 2) == 0) ? (15'h7FF8 + 15'($urandom_range(0, 7)))
                                                   : 15'($urandom);
      for (int j = 0; j < cnt; j++) txn_bytes[j] = 8'($urandom_range(0, lim));
      run_txn(m, b, cnt, 2);
      check_txn($sformatf("rand%0d", t), m, b, cnt, model_answer(m, cnt));
    end

    // Asynchronous reset mid-capture, then idle strobes and a zero-count start.
    wa.delete();
    wd.delete();
    bus.control_reg = {1'b1, 1'b1, 15'h0200, 15'd3};
    @(negedge clk);
    bus.control_reg[31] = 1'b0;
    bus.d_in = 8'hAB;
    bus.d_valid = 1'b1;
    @(negedge clk);
    bus.d_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("midreset outputs", {bus.ram_we, bus.busy, 6'h0, bus.ram_data, 1'b0, bus.ram_addr},
          32'h0);
    check("midreset ready", bus.ready, 32'h0);
    check("midreset answer", bus.answer, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wa.delete();
    wd.delete();
    for (int i = 0; i < 2; i++) begin
      bus.d_in = 8'hCD;
      bus.d_valid = 1'b1;
      @(negedge clk);
    end
    bus.d_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post-reset no write", 32'(wa.size()), 32'd0);
    check("post-reset idle", bus.ready & 32'h3, 32'h0);
    bus.control_reg = {1'b1, 1'b0, 15'h0123, 15'd0};
    @(negedge clk);
    bus.control_reg[31] = 1'b0;
    check("post-reset count0 done", bus.ready & 32'h3, 32'h1);
    repeat (2) @(negedge clk);
    check("post-reset count0 no write", 32'(wa.size()), 32'd0);
    $display("txn reset-midop writes=%0d ready=0x%08h", wa.size(), bus.ready);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
